// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: word stream into the UART transmitter FIFO.
//
// Handshake: a word transfers on a rising clock edge where in_valid and
// in_ready are both high. The master holds in_data stable while in_valid is
// high and may not withdraw a word until it has transferred. in_ready depends
// only on the receiver's state, never on in_valid.
//
// Signals:
//   in_data  : word to transmit (DATA_BITS wide)
//   in_valid : master has a word on in_data
//   in_ready : slave can accept a word this cycle
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with its own baud generator.
// Words arrive on a valid/ready stream, wait in a power-of-two FIFO and are
// sent as start bit, DATA_BITS data bits LSB first, optional parity bit and
// STOP_BITS stop bits. Each bit lasts DIV = CLK_FREQ / BAUD clocks.
//
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset (flushes FIFO, truncates frame)
//   s_if       : input word stream (slave side: in_data, in_valid, in_ready)
//   tx         : registered serial output, idle high
//   busy       : frame in progress or FIFO non-empty
//   fifo_count : occupied FIFO entries
//   dbg_state  : current transmitter state (IDLE=0 START=1 DATA=2 PAR=3 STOP=4)
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 19200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   uart_tx_fifo_if.slave                 s_if,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [2:0]                    dbg_state
);
   localparam int DIV   = CLK_FREQ / BAUD;
   localparam int CNT_W = $clog2(DIV);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CW    = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [CW-1:0]    FULL      = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP  = 3'd4
   } state_t;

   // FIFO storage; no reset needed because the pointers define validity.
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;

   logic                 push;
   logic                 pop;
   logic                 fifo_empty;
   logic                 cnt_last;
   logic [DATA_BITS-1:0] head;
   logic                 head_par;

   // Full refuses a push even when a pop happens on the same edge.
   assign s_if.in_ready = !rst && (count_q != FULL);
   assign push          = s_if.in_valid && s_if.in_ready;
   assign fifo_empty    = (count_q == '0);
   assign head          = mem_q[rd_ptr_q];
   // Odd parity: inverted XOR makes the total number of ones odd.
   assign head_par      = (PARITY == 1) ? ~^head : ^head;
   assign cnt_last      = (cnt_q == CNT_LAST);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Transmitter FSM. tx_d is the line level of the current state; it is
   // registered, so tx lags state_q by one clock.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = 1'b1;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
               par_d   = head_par;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (cnt_last) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            tx_d = shift_q[0];
            if (cnt_last) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PAR: begin
            tx_d = par_q;
            if (cnt_last) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (cnt_last) begin
               cnt_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  // Chain straight into the next frame when data is waiting.
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     shift_d = head;
                     par_d   = head_par;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= s_if.in_data;
      end
   end

   assign tx         = tx_q;
   assign busy       = (state_q != S_IDLE) || !fifo_empty;
   assign fifo_count = count_q;
   assign dbg_state  = state_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo at DIV = 10.
// Four instances: 8N1 depth 16 (main), 8E1, 8O1 and 7N2 (depth 4 each).
// Expected line waveforms come from a bit-level frame model; a line monitor
// on the main instance decodes frames into a queue compared with exp_q.
module tb_uart_tx_fifo;
   localparam int CLK_FREQ = 1000000;
   localparam int BAUD     = 100000;
   localparam int DIV      = 10;
   localparam int FRAME0   = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
   uart_tx_fifo_if #(.DATA_BITS(8)) if1 ();
   uart_tx_fifo_if #(.DATA_BITS(8)) if2 ();
   uart_tx_fifo_if #(.DATA_BITS(7)) if3 ();

   logic       tx0, tx1, tx2, tx3;
   logic       busy0, busy1, busy2, busy3;
   logic [4:0] cnt0;
   logic [2:0] cnt1, cnt2, cnt3;
   logic [2:0] dbg0, dbg1, dbg2, dbg3;

   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
      .clk(clk), .rst(rst), .s_if(if0), .tx(tx0), .busy(busy0),
      .fifo_count(cnt0), .dbg_state(dbg0));
   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
      .clk(clk), .rst(rst), .s_if(if1), .tx(tx1), .busy(busy1),
      .fifo_count(cnt1), .dbg_state(dbg1));
   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
      .clk(clk), .rst(rst), .s_if(if2), .tx(tx2), .busy(busy2),
      .fifo_count(cnt2), .dbg_state(dbg2));
   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
      .clk(clk), .rst(rst), .s_if(if3), .tx(tx3), .busy(busy3),
      .fifo_count(cnt3), .dbg_state(dbg3));

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_word[$];
   int         rx_bad[$];
   int         rx_start[$];
   int         rst_gen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Frame model: line level k clocks after the start bit begins.
   function automatic logic ideal_bit(input int k, input logic [7:0] w, input int nbits,
                                      input int par, input int nstop);
      int b;
      int ones;
      b = k / DIV;
      if (b == 0) return 1'b0;
      if (b <= nbits) return w[b-1];
      ones = 0;
      for (int i = 0; i < nbits; i++) if (w[i]) ones++;
      if (par != 0 && b == nbits + 1) return (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      return 1'b1;
   endfunction

   function automatic int frame_len(input int nbits, input int par, input int nstop);
      return DIV * (1 + nbits + ((par != 0) ? 1 : 0) + nstop);
   endfunction

   function automatic logic [31:0] tx_of(input int i);
      case (i)
         0: return {31'b0, tx0};
         1: return {31'b0, tx1};
         2: return {31'b0, tx2};
         default: return {31'b0, tx3};
      endcase
   endfunction

   function automatic logic [31:0] busy_of(input int i);
      case (i)
         0: return {31'b0, busy0};
         1: return {31'b0, busy1};
         2: return {31'b0, busy2};
         default: return {31'b0, busy3};
      endcase
   endfunction

   function automatic logic [31:0] cnt_of(input int i);
      case (i)
         0: return {27'b0, cnt0};
         1: return {29'b0, cnt1};
         2: return {29'b0, cnt2};
         default: return {29'b0, cnt3};
      endcase
   endfunction

   function automatic logic [31:0] ready_of(input int i);
      case (i)
         0: return {31'b0, if0.in_ready};
         1: return {31'b0, if1.in_ready};
         2: return {31'b0, if2.in_ready};
         default: return {31'b0, if3.in_ready};
      endcase
   endfunction

   task automatic set_in(input int i, input logic v, input logic [7:0] d);
      case (i)
         0: begin if0.in_valid = v; if0.in_data = d; end
         1: begin if1.in_valid = v; if1.in_data = d; end
         2: begin if2.in_valid = v; if2.in_data = d; end
         default: begin if3.in_valid = v; if3.in_data = d[6:0]; end
      endcase
   endtask

   // Line monitor for the main instance: captures a whole frame from each
   // start bit, decodes the data mid-bit and counts deviations from the model.
   initial begin : mon0
      logic       smp [FRAME0];
      logic [7:0] w;
      int         st, gen, bad;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && tx0 === 1'b0) begin
            st = cyc;
            gen = rst_gen;
            aborted = 1'b0;
            smp[0] = tx0;
            for (int k = 1; k < FRAME0; k++) begin
               @(negedge clk);
               smp[k] = tx0;
               if (rst_gen != gen) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted) begin
               for (int i = 0; i < 8; i++) w[i] = smp[DIV * (1 + i) + DIV / 2];
               bad = 0;
               for (int k = 0; k < FRAME0; k++)
                  if (smp[k] !== ideal_bit(k, w, 8, 0, 1)) bad++;
               rx_word.push_back(w);
               rx_bad.push_back(bad);
               rx_start.push_back(st);
            end
         end
      end
   end

   // Single word into an idle, empty instance; checks latency, the full line
   // waveform and the busy fall.
   task automatic send_and_check(input int i, input logic [7:0] w, input int nbits,
                                 input int par, input int nstop, output int e0);
      int flen;
      int bad;
      flen = frame_len(nbits, par, nstop);
      @(negedge clk);
      set_in(i, 1'b1, w);
      chk("ready_idle", ready_of(i), 1);
      @(negedge clk);
      set_in(i, 1'b0, 8'h00);
      e0 = cyc;
      chk("count_after_push", cnt_of(i), 1);
      chk("busy_after_push", busy_of(i), 1);
      @(negedge clk);
      chk("count_after_pop", cnt_of(i), 0);
      chk("tx_high_before_start", tx_of(i), 1);
      bad = 0;
      for (int k = 0; k < flen; k++) begin
         @(negedge clk);
         if (tx_of(i) !== {31'b0, ideal_bit(k, w, nbits, par, nstop)}) bad++;
         if (k == flen - 2) chk("busy_in_last_stop", busy_of(i), 1);
         if (k == flen - 1) chk("busy_fall", busy_of(i), 0);
      end
      chk("frame_waveform", bad, 0);
      @(negedge clk);
      chk("tx_idle_after", tx_of(i), 1);
   endtask

   // Push one word on the main instance leaving in_valid high; also checks
   // back-pressure while full and that a pop on a full FIFO refuses the push.
   task automatic push_hold(input logic [7:0] w, inout int max_cnt);
      int  waited;
      bit  acc;
      waited = 0;
      set_in(0, 1'b1, w);
      forever begin
         acc = if0.in_ready;
         if (int'(cnt0) > max_cnt) max_cnt = int'(cnt0);
         if (cnt0 == 5'd16) chk("ready_low_when_full", ready_of(0), 0);
         @(negedge clk);
         if (acc) break;
         if (cnt0 != 5'd16) chk("full_pop_refuses_push", cnt_of(0), 15);
         waited++;
         if (waited > 400) begin
            chk("push_timeout", waited, 0);
            break;
         end
      end
   endtask

   task automatic wait_rx(input int n, input int limit);
      int t;
      t = 0;
      while (rx_word.size() < n && t < limit) begin
         @(negedge clk);
         t++;
      end
      chk("rx_frame_count", rx_word.size(), n);
   endtask

   task automatic wait_idle0();
      int t;
      t = 0;
      while (busy0 !== 1'b0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("idle_reached", busy_of(0), 0);
   endtask

   // Scoreboard drain: every expected word against the decoded frames.
   task automatic check_rx(input bit b2b);
      int prev;
      int s;
      int b;
      logic [7:0] e;
      logic [7:0] w;
      prev = -1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rx_word.size() == 0) break;
         w = rx_word.pop_front();
         b = rx_bad.pop_front();
         s = rx_start.pop_front();
         chk("rx_word", w, e);
         chk("rx_frame_shape", b, 0);
         if (b2b && prev >= 0) chk("b2b_period", s - prev, FRAME0);
         prev = s;
      end
      exp_q.delete();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int e0;
      int max_cnt;
      int gap;
      logic [7:0] w;

      for (int i = 0; i < 4; i++) set_in(i, 1'b0, 8'h00);

      // Reset state.
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", ready_of(0), 0);
      chk("rst_ready3", ready_of(3), 0);
      chk("rst_tx0", tx_of(0), 1);
      chk("rst_busy0", busy_of(0), 0);
      chk("rst_count0", cnt_of(0), 0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", ready_of(0), 1);

      // 8N1 single word with latency check.
      send_and_check(0, 8'h41, 8, 0, 1, e0);
      exp_q.push_back(8'h41);
      wait_rx(1, 50);
      if (rx_start.size() > 0) chk("start_latency", rx_start[0], e0 + 2);
      check_rx(1'b0);

      // Parity and 7N2 frames.
      send_and_check(1, 8'h41, 8, 2, 1, e0);
      send_and_check(1, 8'h07, 8, 2, 1, e0);
      send_and_check(2, 8'h41, 8, 1, 1, e0);
      send_and_check(3, 8'h55, 7, 0, 2, e0);

      // Push on the pop edge while one word is queued.
      @(negedge clk);
      set_in(0, 1'b1, 8'h3C);
      @(negedge clk);
      chk("pp_count_first", cnt_of(0), 1);
      set_in(0, 1'b1, 8'hC3);
      @(negedge clk);
      chk("pp_count_same", cnt_of(0), 1);
      set_in(0, 1'b0, 8'h00);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hC3);
      wait_rx(2, 400);
      check_rx(1'b1);
      wait_idle0();

      // Burst of 20 words with in_valid held.
      max_cnt = 0;
      @(negedge clk);
      for (int j = 0; j < 20; j++) begin
         w = 8'(j);
         push_hold(w, max_cnt);
         exp_q.push_back(w);
      end
      set_in(0, 1'b0, 8'h00);
      chk("burst_max_count", max_cnt, 16);
      wait_rx(20, 2500);
      check_rx(1'b1);
      wait_idle0();

      // Random words with random gaps.
      max_cnt = 0;
      @(negedge clk);
      for (int j = 0; j < 24; j++) begin
         w = 8'($urandom_range(0, 255));
         push_hold(w, max_cnt);
         exp_q.push_back(w);
         set_in(0, 1'b0, 8'h00);
         gap = $urandom_range(0, 150);
         repeat (gap) @(negedge clk);
      end
      wait_rx(24, 6000);
      check_rx(1'b0);
      wait_idle0();

      // Reset at clock 35 of a frame, then a clean frame.
      @(negedge clk);
      set_in(0, 1'b1, 8'h99);
      @(negedge clk);
      set_in(0, 1'b0, 8'h00);
      repeat (37) @(negedge clk);
      rst_gen++;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tx", tx_of(0), 1);
      chk("midrst_count", cnt_of(0), 0);
      chk("midrst_busy", busy_of(0), 0);
      chk("midrst_ready", ready_of(0), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      send_and_check(0, 8'hA5, 8, 0, 1, e0);
      exp_q.push_back(8'hA5);
      wait_rx(1, 50);
      check_rx(1'b0);
      repeat (20) @(negedge clk);
      chk("no_extra_frames", rx_word.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter that accepts words over a valid/ready stream, buffers them in an internal FIFO, and serialises each word onto `tx`. It contains its own baud generator, so no separate TX controller is needed. Data width, parity, stop bits, FIFO depth and bit rate are all configurable. It sits between any byte producer (button/counter logic, message ROM sequencer, loopback) and the board's serial output pin.

## Interface
- `CLK_FREQ`, default 100000000: clock frequency in Hz.
- `BAUD`, default 19200: bit rate. `DIV = CLK_FREQ / BAUD`, integer-truncated; `DIV >= 2` is required.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `FIFO_DEPTH`, default 16: buffer entries; must be a power of 2 and at least 2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset; synchronous, active-high.
- `in_data` in DATA_BITS: word to transmit.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the FIFO can accept a word.
- `tx` out 1: serial line, idle high, registered.
- `busy` out 1: a frame is in progress or the FIFO is non-empty.
- `fifo_count` out clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.

## Operation
- **Push.** A push occurs on a rising edge when `in_valid && in_ready`. The word is written at the write pointer.
- **`in_ready`.** `in_ready = !rst && (fifo_count != FIFO_DEPTH)`. When full, a push is refused even if a pop happens in the same cycle.
- **Pointers and count.** Read and write pointers wrap modulo `FIFO_DEPTH`. On a simultaneous push and pop, `fifo_count` is unchanged.
- **Frame format.** One start bit (0), then `DATA_BITS` data bits LSB first, then an optional parity bit, then `STOP_BITS` stop bits (1).
  - Odd parity: the parity bit makes the total count of ones (data plus parity) odd.
  - Even parity: the total count of ones is even.
- **Bit timing.** Each bit lasts exactly `DIV` clocks. The baud counter runs 0..DIV-1 and is reset to 0 at every frame start.
- **State machine:** IDLE, START, DATA, PAR, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0]; shift right every DIV cycles. After bit `DATA_BITS-1`, go to PAR if `PARITY != 0`, otherwise to STOP.
  - PAR: `tx`=parity bit (computed when the word is popped) for DIV cycles, then go to STOP.
  - STOP: `tx`=1 for `STOP_BITS*DIV` cycles. On the last stop cycle:
    - FIFO non-empty: pop and go directly to START, with no idle gap.
    - FIFO empty: go to IDLE.
- **`busy`.** `busy = (state != IDLE) || (fifo_count != 0)`.
- **Reset.** Effective at the next edge, including mid-frame. State becomes IDLE, `tx`=1, the FIFO is flushed (`fifo_count`=0, pointers 0), `busy`=0, and the partial frame is truncated.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `fifo_count`=0. `in_ready`=0 while `rst` is high and 1 on the first cycle after.
- **Latency.** Push on edge E0 with the FIFO empty and state IDLE:
  - `fifo_count`=1 after E0.
  - Pop on E0+1; `fifo_count` returns to 0.
  - `tx` falls after edge E0+2.
- **Frame length.** `DIV*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS)` clocks.
- **Back-to-back frames.** The period equals the frame length exactly; the next start bit begins the cycle after the last stop cycle.
- **`busy` fall.** `busy` falls on the same edge at which `tx` is in its final stop cycle's successor (state enters IDLE) with the FIFO empty.

## Test plan
Benches use `CLK_FREQ`=1000000 and `BAUD`=100000, so `DIV`=10.

- **8N1, single word.** Push 0x41 → `tx` low for 10 clocks, then 1,0,0,0,0,0,1,0 at 10 clocks each, then high for 10. Frame is 100 clocks with start 2 cycles after the push. `busy` falls after the stop bit.
- **Parity.**
  - `PARITY`=2, push 0x41 → parity bit 0, 110-clock frame.
  - `PARITY`=2, push 0x07 → parity bit 1.
  - `PARITY`=1, push 0x41 → parity bit 1.
- **Burst and back-pressure.** `FIFO_DEPTH`=16, hold `in_valid` with 20 words 0x00..0x13.
  - `in_ready` is low whenever `fifo_count`=16.
  - All 20 words appear on `tx` in order, with start bits exactly 100 clocks apart.
- **7 data bits, 2 stop, no parity.** Push 0x55 → 7 data bits 1,0,1,0,1,0,1, then 20 clocks high. Frame is 100 clocks; bit 7 of `in_data` is absent.
- **Reset mid-frame.** Assert `rst` for 1 cycle at clock 35 of a frame → `tx`=1 and `fifo_count`=0 at the next edge, `busy`=0. A subsequent push of 0xA5 produces a clean 100-clock frame.
- **Simultaneous push and pop.** Push exactly on the pop edge while `fifo_count`=1 → `fifo_count` stays 1 and the words are sent in order. Push at `fifo_count`=16 on a pop edge → push refused and `fifo_count` becomes 15.
